// File: rtl/staged_mac_pkg.sv
// Shared types and the output post-processing function for the staged multi-lane MAC.
// The post function works in 64 bits so any ACC_W/OUT_W up to 63 bits can use it.
package staged_mac_pkg;

    typedef enum logic [1:0] {
        BIAS  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

    typedef struct packed {
        logic [63:0] data;
        logic        clip;
    } post_t;

    // Shift, optional ReLU, then clamp to a signed out_w-bit range.
    function automatic post_t sat_post(input logic signed [63:0] x,
                                       input int                 shift,
                                       input logic               relu,
                                       input int                 out_w);
        logic signed [63:0] y;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        post_t              r;
        y = x >>> shift;
        if (relu && (y < 64'sd0)) begin
            y = 64'sd0;
        end
        max_v  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v  = -max_v - 64'sd1;
        r.data = y;
        r.clip = 1'b0;
        if (y > max_v) begin
            r.data = max_v;
            r.clip = 1'b1;
        end else if (y < min_v) begin
            r.data = min_v;
            r.clip = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/staged_mac_vec_lane_tree.sv
// Two-stage lane datapath: P1 registers the per-lane signed products,
// P2 registers their sum sign-extended to the accumulator width.
module mac_lane_tree
    import staged_mac_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [2*DATA_W*LANES-1:0]   in_data,
    output logic                        sum_valid,
    output logic [ACC_W-1:0]            sum
);

    localparam int PROD_W = 2 * DATA_W;

    logic [LANES-1:0][PROD_W-1:0] prod_d, prod_q;
    logic                         valid1_d, valid1_q;
    logic [ACC_W-1:0]             sum_d, sum_q;
    logic                         valid2_d, valid2_q;

    always_comb begin
        prod_d   = prod_q;
        valid1_d = in_valid;
        if (in_valid) begin
            for (int i = 0; i < LANES; i++) begin
                prod_d[i] = PROD_W'($signed(in_data[2*DATA_W*i + DATA_W +: DATA_W]))
                          * PROD_W'($signed(in_data[2*DATA_W*i +: DATA_W]));
            end
        end
    end

    always_comb begin
        sum_d    = sum_q;
        valid2_d = valid1_q;
        if (valid1_q) begin
            sum_d = '0;
            for (int i = 0; i < LANES; i++) begin
                sum_d = sum_d + ACC_W'($signed(prod_q[i]));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q   <= '0;
            valid1_q <= 1'b0;
            sum_q    <= '0;
            valid2_q <= 1'b0;
        end else begin
            prod_q   <= prod_d;
            valid1_q <= valid1_d;
            sum_q    <= sum_d;
            valid2_q <= valid2_d;
        end
    end

    assign sum_valid = valid2_q;
    assign sum       = sum_q;

endmodule

// File: rtl/staged_mac_vec.sv
// Multi-lane staged MAC: one AXI-Stream packet (bias beat + weight/activation beats)
// in, one shifted / ReLU'd / saturated result out per packet.
module staged_mac_vec
    import staged_mac_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int BIAS_W    = 16,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 0,
    parameter int RELU_EN   = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [2*DATA_W*LANES-1:0] SD_AXIS_TDATA,
    input  logic                      SD_AXIS_TVALID,
    input  logic                      SD_AXIS_TLAST,
    output logic                      SD_AXIS_TREADY,
    output logic [OUT_W-1:0]          MO_AXIS_TDATA,
    output logic                      MO_AXIS_TUSER,
    output logic                      MO_AXIS_TVALID,
    output logic                      MO_AXIS_TLAST,
    input  logic                      MO_AXIS_TREADY
);

    state_t           state_d, state_q;
    logic [1:0]       cnt_d, cnt_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic             tready_d, tready_q;
    logic [OUT_W-1:0] out_data_d, out_data_q;
    logic             out_user_d, out_user_q;
    logic             out_valid_d, out_valid_q;

    logic             s_accept;
    logic             mo_handshake;
    logic             lane_valid;
    logic [ACC_W-1:0] lane_sum;
    logic [ACC_W-1:0] bias_ext;
    post_t            post_r;

    assign s_accept     = SD_AXIS_TVALID && tready_q;
    assign mo_handshake = out_valid_q && MO_AXIS_TREADY;
    assign bias_ext     = ACC_W'($signed(SD_AXIS_TDATA[BIAS_W-1:0]));

    mac_lane_tree #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane_tree (
        .clk       (ACLK),
        .rst       (ARESET),
        .in_valid  (s_accept && (state_q == ACCUM)),
        .in_data   (SD_AXIS_TDATA),
        .sum_valid (lane_valid),
        .sum       (lane_sum)
    );

    // P3 accumulates whenever a lane sum emerges; DRAIN waits for the last one to land.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        out_valid_d = out_valid_q;
        post_r      = sat_post(64'($signed(acc_q)), OUT_SHIFT, (RELU_EN != 0), OUT_W);

        if (lane_valid) begin
            acc_d = acc_q + lane_sum;
        end

        case (state_q)
            BIAS: begin
                if (s_accept) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    state_d = SD_AXIS_TLAST ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                if (s_accept && SD_AXIS_TLAST) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_CYCLES) begin
                    out_data_d  = OUT_W'(post_r.data);
                    out_user_d  = post_r.clip;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            OUT: begin
                if (mo_handshake) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    state_d     = BIAS;
                end
            end
            default: state_d = BIAS;
        endcase

        tready_d = (state_d == BIAS) || (state_d == ACCUM);
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= BIAS;
            cnt_q       <= '0;
            acc_q       <= '0;
            tready_q    <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            tready_q    <= tready_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign SD_AXIS_TREADY = tready_q;
    assign MO_AXIS_TDATA  = out_data_q;
    assign MO_AXIS_TUSER  = out_user_q;
    assign MO_AXIS_TVALID = out_valid_q;
    assign MO_AXIS_TLAST  = out_valid_q;

endmodule

// File: tb/tb_staged_mac_vec.sv
// Bench for staged_mac_vec: three instances (default, OUT_W=16, ReLU+shift) share one
// input stream and are each compared with a packet-level arithmetic model.
module tb_staged_mac_vec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        mo_ready = 1'b1;

    logic        s0_tready, s1_tready, s2_tready;
    logic [31:0] m0_tdata, m2_tdata;
    logic [15:0] m1_tdata;
    logic        m0_tuser, m1_tuser, m2_tuser;
    logic        m0_tvalid, m1_tvalid, m2_tvalid;
    logic        m0_tlast, m1_tlast, m2_tlast;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_hs_cyc = 0;

    byte w_arr[16][2];
    byte a_arr[16][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    staged_mac_vec u_dut (
        .ACLK(clk), .ARESET(rst),
        .SD_AXIS_TDATA(s_tdata), .SD_AXIS_TVALID(s_tvalid), .SD_AXIS_TLAST(s_tlast),
        .SD_AXIS_TREADY(s0_tready),
        .MO_AXIS_TDATA(m0_tdata), .MO_AXIS_TUSER(m0_tuser), .MO_AXIS_TVALID(m0_tvalid),
        .MO_AXIS_TLAST(m0_tlast), .MO_AXIS_TREADY(mo_ready)
    );

    staged_mac_vec #(.OUT_W(16)) u_sat (
        .ACLK(clk), .ARESET(rst),
        .SD_AXIS_TDATA(s_tdata), .SD_AXIS_TVALID(s_tvalid), .SD_AXIS_TLAST(s_tlast),
        .SD_AXIS_TREADY(s1_tready),
        .MO_AXIS_TDATA(m1_tdata), .MO_AXIS_TUSER(m1_tuser), .MO_AXIS_TVALID(m1_tvalid),
        .MO_AXIS_TLAST(m1_tlast), .MO_AXIS_TREADY(mo_ready)
    );

    staged_mac_vec #(.RELU_EN(1), .OUT_SHIFT(1)) u_relu (
        .ACLK(clk), .ARESET(rst),
        .SD_AXIS_TDATA(s_tdata), .SD_AXIS_TVALID(s_tvalid), .SD_AXIS_TLAST(s_tlast),
        .SD_AXIS_TREADY(s2_tready),
        .MO_AXIS_TDATA(m2_tdata), .MO_AXIS_TUSER(m2_tuser), .MO_AXIS_TVALID(m2_tvalid),
        .MO_AXIS_TLAST(m2_tlast), .MO_AXIS_TREADY(mo_ready)
    );

    task automatic check_output(input string tag, input logic signed [63:0] obs,
                                input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Result as the arithmetic reads: shift, ReLU, clamp to out_w bits.
    task automatic model_post(input longint x, input int shift, input bit relu, input int out_w,
                              output longint y, output bit clip);
        longint hi, lo;
        y    = x / (longint'(1) << shift);
        if ((x < 0) && (x % (longint'(1) << shift) != 0)) y = y - 1;
        if (relu && y < 0) y = 0;
        hi   = (longint'(1) << (out_w - 1)) - 1;
        lo   = -(longint'(1) << (out_w - 1));
        clip = 1'b0;
        if (y > hi) begin y = hi; clip = 1'b1; end
        else if (y < lo) begin y = lo; clip = 1'b1; end
    endtask

    task automatic drive_beat(input logic [31:0] data, input logic last, input int gap_max,
                              input string tag, output int acc_cyc);
        int   n;
        logic rdy;
        repeat ($urandom_range(0, gap_max)) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b1;
        s_tdata  = data;
        s_tlast  = last;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            rdy = s0_tready;
            @(posedge clk); #1;
            n++;
        end
        check_output({tag, "_accept"}, 64'(rdy), 64'd1);
        acc_cyc  = cyc;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Sends bias + nb beats from w_arr/a_arr, then checks latency, results and handshake.
    task automatic apply_stimulus(input int bias, input int nb, input int gap_max, input int hold,
                                  input bit chk_b2b, input string tag);
        int     exp_acc, acc_cyc, n;
        longint e0, e1, e2;
        bit     c0, c1, c2;
        exp_acc = bias;
        for (int b = 0; b < nb; b++)
            for (int l = 0; l < 2; l++)
                exp_acc += int'(w_arr[b][l]) * int'(a_arr[b][l]);
        model_post(longint'(exp_acc), 0, 1'b0, 32, e0, c0);
        model_post(longint'(exp_acc), 0, 1'b0, 16, e1, c1);
        model_post(longint'(exp_acc), 1, 1'b1, 32, e2, c2);
        mo_ready = (hold == 0);

        drive_beat({16'($urandom), 16'(bias)}, (nb == 0), chk_b2b ? 0 : gap_max, tag, acc_cyc);
        if (chk_b2b) check_output({tag, "_b2b_bias"}, 64'(acc_cyc), 64'(last_hs_cyc + 1));
        for (int b = 0; b < nb; b++)
            drive_beat({w_arr[b][1], a_arr[b][1], w_arr[b][0], a_arr[b][0]}, (b == nb - 1),
                       gap_max, tag, acc_cyc);

        n = 0;
        while (!m0_tvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_output({tag, "_latency"}, 64'(cyc - acc_cyc), 64'd4);
        check_output({tag, "_data"}, $signed(m0_tdata), e0);
        check_output({tag, "_user"}, 64'(m0_tuser), 64'(c0));
        check_output({tag, "_last"}, 64'(m0_tlast), 64'd1);
        check_output({tag, "_sat_data"}, $signed(m1_tdata), e1);
        check_output({tag, "_sat_user"}, 64'(m1_tuser), 64'(c1));
        check_output({tag, "_relu_data"}, $signed(m2_tdata), e2);
        check_output({tag, "_relu_user"}, 64'(m2_tuser), 64'(c2));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_output({tag, "_hold_valid"}, 64'({m0_tvalid, m0_tlast}), 64'd3);
            check_output({tag, "_hold_data"}, $signed(m0_tdata), e0);
            check_output({tag, "_hold_sready"}, 64'(s0_tready), 64'd0);
        end
        mo_ready = 1'b1;
        @(posedge clk); #1;
        last_hs_cyc = cyc;
        check_output({tag, "_valid_drop"}, 64'({m0_tvalid, m1_tvalid, m2_tvalid}), 64'd0);
        check_output({tag, "_sready_back"}, 64'(s0_tready), 64'd1);
    endtask

    task automatic load_test1();
        w_arr[0][1] = 8'sd119;  a_arr[0][1] = -8'sd3;
        w_arr[0][0] = -8'sd122; a_arr[0][0] = -8'sd15;
        w_arr[1][1] = 8'sd0;    a_arr[1][1] = 8'sd0;
        w_arr[1][0] = -8'sd107; a_arr[1][0] = 8'sd13;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc_cyc, seen, nb;

        #1 rst = 1'b1;
        #1;
        check_output("reset_outputs",
                     64'({s0_tready, m0_tvalid, m0_tlast, m0_tuser}), 64'd0);
        check_output("reset_data", 64'(m0_tdata), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_output("sready_before_edge", 64'(s0_tready), 64'd0);
        @(posedge clk); #1;
        check_output("sready_after_edge", 64'(s0_tready), 64'd1);

        $display("[TB] directed: bias plus two beats");
        load_test1();
        apply_stimulus(-1028, 2, 0, 0, 1'b0, "t1");

        $display("[TB] directed: bias-only packet");
        apply_stimulus(5000, 0, 0, 0, 1'b0, "t2");

        $display("[TB] directed: extreme negative operands, with and without gaps");
        w_arr[0][1] = -8'sd128; a_arr[0][1] = -8'sd128;
        w_arr[0][0] = -8'sd128; a_arr[0][0] = -8'sd128;
        apply_stimulus(5000, 1, 0, 0, 1'b0, "t3");
        apply_stimulus(5000, 1, 4, 0, 1'b0, "t3gap");

        $display("[TB] directed: downstream backpressure then back-to-back bias");
        load_test1();
        apply_stimulus(-1028, 2, 0, 10, 1'b0, "t4");
        apply_stimulus(-1028, 2, 0, 0, 1'b1, "t4next");

        $display("[TB] directed: saturation and ReLU");
        w_arr[0][1] = 8'sd0;   a_arr[0][1] = 8'sd0;
        w_arr[0][0] = 8'sd127; a_arr[0][0] = 8'sd127;
        apply_stimulus(30000, 1, 0, 0, 1'b0, "t5sat");
        w_arr[0][0] = -8'sd128; a_arr[0][0] = 8'sd127;
        apply_stimulus(-2000, 1, 0, 0, 1'b0, "t5relu");

        $display("[TB] directed: reset mid-packet");
        load_test1();
        drive_beat({16'h0, 16'(-1028)}, 1'b0, 0, "t6", acc_cyc);
        drive_beat({w_arr[0][1], a_arr[0][1], w_arr[0][0], a_arr[0][0]}, 1'b0, 0, "t6", acc_cyc);
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tdata  = {w_arr[1][1], a_arr[1][1], w_arr[1][0], a_arr[1][0]};
        #2 rst = 1'b1;
        #1;
        check_output("t6_async_ctrl",
                     64'({s0_tready, m0_tvalid, m0_tlast, m0_tuser}), 64'd0);
        check_output("t6_async_data", 64'(m0_tdata), 64'd0);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (m0_tvalid) seen++;
        end
        check_output("t6_no_result", 64'(seen), 64'd0);
        apply_stimulus(-1028, 2, 0, 0, 1'b0, "t6after");

        $display("[TB] random packets");
        for (int p = 0; p < 20; p++) begin
            nb = $urandom_range(0, 8);
            for (int b = 0; b < nb; b++)
                for (int l = 0; l < 2; l++) begin
                    w_arr[b][l] = byte'($urandom);
                    a_arr[b][l] = byte'($urandom);
                end
            apply_stimulus(int'($signed(16'($urandom))), nb, $urandom_range(0, 3), $urandom_range(0, 3),
                           1'b0, $sformatf("rand%0d", p));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
